// File: rtl/bus_node.sv
`default_nettype none
// ============================================================================
// Module   : bus_node
// Purpose  : UART bus endpoint; receives {data, CRC-8} frames and answers
//            with an ACK/NAK byte. Define BUS_NODE_TIMEOUT_EN to enable the
//            inter-byte timeout between the data and CRC bytes.
// Revision : 1.0 - initial release
// ============================================================================

module bus_node #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         TIMEOUT_CLKS = 8680,
  parameter logic [7:0] ACK_BYTE     = 8'h06,
  parameter logic [7:0] NAK_BYTE     = 8'h15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] readdata,
  output logic       done,
  output logic       crc_error,
  output logic       con_error,
  output logic       busy
);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("bus_node: CLKS_PER_BIT must be at least 4");
  end
  if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
    $error("bus_node: TIMEOUT_CLKS must be positive");
  end

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] c_rx_idle  = 2'd0;
  localparam logic [1:0] c_rx_start = 2'd1;
  localparam logic [1:0] c_rx_data  = 2'd2;
  localparam logic [1:0] c_rx_stop  = 2'd3;

  localparam logic [1:0] c_st_wait_data = 2'd0;
  localparam logic [1:0] c_st_wait_crc  = 2'd1;
  localparam logic [1:0] c_st_check     = 2'd2;
  localparam logic [1:0] c_st_reply     = 2'd3;

  function automatic logic [7:0] f_crc8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  logic               w_rx_fall;
  logic [1:0]         r_rx_state;
  logic [c_cnt_w-1:0] r_rx_cnt;
  logic [2:0]         r_rx_idx;
  logic [7:0]         r_rx_shift;
  logic               r_rx_valid, r_rx_ferr;

  logic               r_hold_full;
  logic [7:0]         r_hold_data;
  logic               w_byte_avail, w_consume, w_overrun, w_match, w_timeout;
  logic [7:0]         w_byte;

  logic [1:0]         r_state;
  logic [7:0]         r_cand, r_reply, r_readdata;
  logic               r_done, r_crc_error, r_con_error;

  logic               r_tx, r_busy;
  logic [c_cnt_w-1:0] r_tx_cnt;
  logic [3:0]         r_tx_idx;
  logic [8:0]         r_tx_frame;
  logic               w_tx_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // Receive engine: byte-valid / framing-error pulse at mid-stop-bit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state <= c_rx_idle;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        c_rx_idle: begin
          if (w_rx_fall) begin
            r_rx_state <= c_rx_start;
            r_rx_cnt   <= '0;
          end
        end
        c_rx_start: begin
          if (r_rx_cnt == c_half) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_sync ? c_rx_idle : c_rx_data;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        c_rx_data: begin
          if (r_rx_cnt == c_bit_last) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_idx   <= r_rx_idx + 1'b1;
            if (r_rx_idx == 3'd7) begin
              r_rx_state <= c_rx_stop;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        c_rx_stop: begin
          if (r_rx_cnt == c_bit_last) begin
            r_rx_cnt   <= '0;
            r_rx_state <= c_rx_idle;
            r_rx_valid <= r_rx_sync;
            r_rx_ferr  <= ~r_rx_sync;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= c_rx_idle;
      endcase
    end
  end

  // A held byte is older than one arriving this cycle, so it is served first
  assign w_byte_avail = r_hold_full | r_rx_valid;
  assign w_byte       = r_hold_full ? r_hold_data : r_rx_shift;
  assign w_consume    = w_byte_avail &
                        ((r_state == c_st_wait_data) | (r_state == c_st_wait_crc));
  assign w_overrun    = r_rx_valid & r_hold_full & ~w_consume;
  assign w_match      = (f_crc8(r_cand) == w_byte);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (r_rx_valid && (r_hold_full || !w_consume)) begin
      r_hold_full <= 1'b1;
      r_hold_data <= r_rx_shift;
    end else if (w_consume) begin
      r_hold_full <= 1'b0;
    end
  end

`ifdef BUS_NODE_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CLKS - 1);
  logic              w_rx_start_det;
  logic [c_to_w-1:0] r_to_cnt;

  assign w_rx_start_det = (r_rx_state == c_rx_idle) & w_rx_fall;

  always_ff @(posedge clock) begin
    if (reset || r_state != c_st_wait_crc || w_rx_start_det) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_to_last) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == c_st_wait_crc) & (r_to_cnt == c_to_last) & ~w_byte_avail;
`else
  assign w_timeout = 1'b0;
`endif

  // Frame FSM: the CRC verdict is registered on entry to CHECK
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_st_wait_data;
      r_cand      <= '0;
      r_reply     <= '0;
      r_readdata  <= '0;
      r_done      <= 1'b0;
      r_crc_error <= 1'b0;
      r_con_error <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_crc_error <= 1'b0;
      r_con_error <= r_rx_ferr | w_overrun | w_timeout;
      case (r_state)
        c_st_wait_data: begin
          if (w_byte_avail) begin
            r_cand  <= w_byte;
            r_state <= c_st_wait_crc;
          end
        end
        c_st_wait_crc: begin
          if (w_byte_avail) begin
            r_state <= c_st_check;
            if (w_match) begin
              r_readdata <= r_cand;
              r_done     <= 1'b1;
              r_reply    <= ACK_BYTE;
            end else begin
              r_crc_error <= 1'b1;
              r_reply     <= NAK_BYTE;
            end
          end else if (r_rx_ferr || w_timeout) begin
            r_state <= c_st_wait_data;
          end
        end
        c_st_check: r_state <= c_st_reply;
        c_st_reply: begin
          if (w_tx_last) begin
            r_state <= c_st_wait_data;
          end
        end
        default: r_state <= c_st_wait_data;
      endcase
    end
  end

  assign w_tx_last = r_busy & (r_tx_cnt == c_bit_last) & (r_tx_idx == 4'd9);

  // Transmit engine: start bit goes out the cycle after CHECK
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_frame <= '1;
    end else if (r_state == c_st_check) begin
      r_tx       <= 1'b0;
      r_busy     <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_frame <= {1'b1, r_reply};
    end else if (r_busy) begin
      if (r_tx_cnt == c_bit_last) begin
        r_tx_cnt <= '0;
        if (r_tx_idx == 4'd9) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end else begin
          r_tx_idx   <= r_tx_idx + 1'b1;
          r_tx       <= r_tx_frame[0];
          r_tx_frame <= {1'b1, r_tx_frame[8:1]};
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign readdata  = r_readdata;
  assign done      = r_done;
  assign crc_error = r_crc_error;
  assign con_error = r_con_error;

endmodule

`default_nettype wire

// File: tb/tb_bus_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_node
// Purpose  : Self-checking bench for bus_node (frame table + corner cases).
// Revision : 1.0 - initial release
// ============================================================================

module tb_bus_node;

  localparam int CPB = 8;
  localparam int TO  = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       tx, done, crc_error, con_error, busy;
  logic [7:0] readdata;

  always #5 clock = ~clock;

  bus_node #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO),
    .ACK_BYTE    (8'h06),
    .NAK_BYTE    (8'h15)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .readdata (readdata),
    .done     (done),
    .crc_error(crc_error),
    .con_error(con_error),
    .busy     (busy)
  );

  int         n_cmp  = 0;
  int         n_err  = 0;
  int         n_done = 0;
  int         n_crc  = 0;
  int         n_con  = 0;
  int         epoch  = 0;
  logic [7:0] exp_reply[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] crc;
    logic       stop;
    logic       send_crc;
    int         d_done;
    int         d_crc;
    int         d_con;
    logic [7:0] rd;
    logic       has_reply;
    logic [7:0] reply;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int idle);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (idle) @(negedge clock);
  endtask

  task automatic wait_reply(input string name);
    int   t;
    logic saw;
    t   = 0;
    saw = busy;
    while (!saw && t < 200) begin
      @(negedge clock);
      t++;
      saw = busy;
    end
    while (busy && t < 400) begin
      @(negedge clock);
      t++;
    end
    check(name, {31'd0, saw && !busy}, 32'd1);
  endtask

  // Pulse counters, pulse-width checks and reply-start latency
  initial begin
    logic pd, pc, pn, chk_next;
    pd = 0; pc = 0; pn = 0; chk_next = 0;
    forever begin
      @(negedge clock);
      if (chk_next) begin
        check("reply_start_busy", {31'd0, busy}, 32'd1);
        check("reply_start_tx", {31'd0, tx}, 32'd0);
        chk_next = 0;
      end
      if (done) begin
        n_done++;
        check("done_width", {31'd0, pd}, 32'd0);
      end
      if (crc_error) begin
        n_crc++;
        check("crc_error_width", {31'd0, pc}, 32'd0);
      end
      if (con_error) begin
        n_con++;
        check("con_error_width", {31'd0, pn}, 32'd0);
      end
      if (done || crc_error) chk_next = 1;
      pd = done; pc = crc_error; pn = con_error;
    end
  end

  // Reply decoder: scoreboard pop on every completed reply byte
  initial begin
    int         ep;
    logic [7:0] b;
    logic       st, sp;
    forever begin
      @(negedge clock);
      if (busy && !tx && !reset) begin
        ep = epoch;
        repeat (CPB / 2) @(negedge clock);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clock);
        sp = tx;
        if (ep == epoch) begin
          check("reply_start_bit", {31'd0, st}, 32'd0);
          check("reply_stop_bit", {31'd0, sp}, 32'd1);
          if (exp_reply.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_reply: got %0h expected none", b);
          end else begin
            check("reply_byte", {24'd0, b}, {24'd0, exp_reply.pop_front()});
          end
        end
      end
    end
  end

  // Busy width per reply
  initial begin
    int w, ep;
    w = 0; ep = 0;
    forever begin
      @(negedge clock);
      if (busy) begin
        if (w == 0) ep = epoch;
        w++;
      end else if (w != 0) begin
        if (ep == epoch) check("busy_width", w, 10 * CPB);
        w = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_done, b_crc, b_con, t;

    vecs[0] = '{8'hA5, 8'h72, 1'b1, 1'b1, 1, 0, 0, 8'hA5, 1'b1, 8'h06};
    vecs[1] = '{8'h01, 8'h08, 1'b1, 1'b1, 0, 1, 0, 8'hA5, 1'b1, 8'h15};
    vecs[2] = '{8'h3C, 8'h00, 1'b0, 1'b0, 0, 0, 1, 8'hA5, 1'b0, 8'h00};
    vecs[3] = '{8'h01, 8'h07, 1'b1, 1'b1, 1, 0, 0, 8'h01, 1'b1, 8'h06};
    vecs[4] = '{8'hFF, 8'hF3, 1'b1, 1'b1, 1, 0, 0, 8'hFF, 1'b1, 8'h06};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00, 1'b1, 8'h06};

    repeat (3) @(negedge clock);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_readdata", {24'd0, readdata}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_crc_error", {31'd0, crc_error}, 32'd0);
    check("reset_con_error", {31'd0, con_error}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      b_done = n_done; b_crc = n_crc; b_con = n_con;
      if (vecs[i].has_reply) exp_reply.push_back(vecs[i].reply);
      send_byte(vecs[i].data, vecs[i].stop, 2 * CPB);
      if (vecs[i].send_crc) send_byte(vecs[i].crc, 1'b1, 2);
      if (vecs[i].has_reply) wait_reply("vec_reply_timeout");
      else repeat (3 * CPB) @(negedge clock);
      repeat (4) @(negedge clock);
      check("vec_done_count", n_done - b_done, vecs[i].d_done);
      check("vec_crc_count", n_crc - b_crc, vecs[i].d_crc);
      check("vec_con_count", n_con - b_con, vecs[i].d_con);
      check("vec_readdata", {24'd0, readdata}, {24'd0, vecs[i].rd});
    end

    // Back-to-back: second data byte completes while the ACK is on the wire
    b_done = n_done; b_con = n_con;
    exp_reply.push_back(8'h06);
    exp_reply.push_back(8'h06);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h72, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h07, 1'b1, 2);
    t = 0;
    while ((n_done - b_done < 2 || busy) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    repeat (4) @(negedge clock);
    check("b2b_done_count", n_done - b_done, 2);
    check("b2b_con_count", n_con - b_con, 0);
    check("b2b_readdata", {24'd0, readdata}, 32'h01);
    check("b2b_replies_left", exp_reply.size(), 0);

    // Reset in the middle of a reply
    exp_reply.push_back(8'h06);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h72, 1'b1, 0);
    t = 0;
    while (!busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    repeat (20) @(negedge clock);
    epoch++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_readdata", {24'd0, readdata}, 32'd0);
    exp_reply.delete();
    repeat (12 * CPB) @(negedge clock);
    b_done = n_done;
    exp_reply.push_back(8'h06);
    send_byte(8'h01, 1'b1, 2 * CPB);
    send_byte(8'h07, 1'b1, 2);
    wait_reply("post_reset_reply_timeout");
    repeat (4) @(negedge clock);
    check("post_reset_done_count", n_done - b_done, 1);
    check("post_reset_readdata", {24'd0, readdata}, 32'h01);

`ifdef BUS_NODE_TIMEOUT_EN
    b_con = n_con;
    send_byte(8'h55, 1'b1, 0);
    repeat (TO + 10) @(negedge clock);
    check("timeout_con_count", n_con - b_con, 1);
    b_done = n_done;
    exp_reply.push_back(8'h06);
    send_byte(8'h01, 1'b1, 2 * CPB);
    send_byte(8'h07, 1'b1, 2);
    wait_reply("timeout_reply_timeout");
    repeat (4) @(negedge clock);
    check("timeout_done_count", n_done - b_done, 1);
    check("timeout_readdata", {24'd0, readdata}, 32'h01);
`endif

    repeat (2 * CPB) @(negedge clock);
    check("replies_left", exp_reply.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_node.md
# bus_node

Peripheral-side endpoint of the UART bus driven by the arbiter. It deserializes two-byte frames (data, CRC-8) from the arbiter's `tx` line and validates the checksum. It delivers good data to local logic and serializes a one-byte ACK/NAK reply back on its own `tx` line. UART receive and transmit bit engines are built in; no external UART modules are instantiated.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `TIMEOUT_CLKS`, 8680, idle cycles allowed between data byte and CRC byte (only with the timeout macro).
- `ACK_BYTE`, 8'h06, reply for a valid frame.
- `NAK_BYTE`, 8'h15, reply for a CRC mismatch.

- `clock` in 1 — single system clock.
- `reset` in 1 — synchronous, active-high reset.
- `rx` in 1 — serial input from the arbiter; asynchronous, idle high.
- `tx` out 1 — serial reply to the arbiter; idle high.
- `readdata` out 8 — last valid data byte; held until the next valid frame.
- `done` out 1 — one-cycle pulse when `readdata` is updated.
- `crc_error` out 1 — one-cycle pulse on CRC mismatch.
- `con_error` out 1 — one-cycle pulse on framing error or timeout.
- `busy` out 1 — high while a reply byte is being transmitted.

## Operation
- Serial format is 8N1, LSB first. `rx` is passed through a 2-flop synchronizer.
- Receive engine:
  - A falling edge starts reception.
  - The start bit is re-checked at CLKS_PER_BIT/2 and treated as a glitch if high.
  - Data bits are sampled at bit centres, then the stop bit is sampled.
  - Stop = 0 is a framing error: the byte is discarded and `con_error` pulses.
- Checksum is CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over the data byte only.
- Frame FSM:
  - WAIT_DATA: a good byte is latched as the candidate → WAIT_CRC.
  - WAIT_CRC: a good byte is latched as the received CRC → CHECK. A framing error → WAIT_DATA.
  - CHECK, one cycle:
    - On match: `readdata` ← candidate, `done` = 1, reply = ACK_BYTE.
    - On mismatch: `crc_error` = 1, `readdata` unchanged, reply = NAK_BYTE.
    - → REPLY.
  - REPLY: transmit the reply byte. When the stop bit completes → WAIT_DATA.
- The receive engine runs independently of REPLY. A byte completing during REPLY is taken as the next frame's data byte; the FSM sees it in WAIT_DATA via a one-entry holding register. If a second byte completes while the holding register is full, the older byte is overwritten and `con_error` pulses.
- Reset mid-operation:
  - All state is cleared.
  - `tx` goes high on the cycle after reset is sampled, even mid-byte.
  - A partial frame is lost.
  - Reset values: `readdata` = 0, `done`/`crc_error`/`con_error`/`busy` = 0, `tx` = 1, FSM = WAIT_DATA.

## Timing
- The receive engine asserts byte-valid on the cycle the stop bit is sampled, at mid-stop-bit.
- CHECK is the cycle after the CRC byte is valid; `done`, `crc_error` and `readdata` change there.
- `busy` rises and `tx` drops for the start bit on the cycle after CHECK.
- Each reply bit lasts exactly CLKS_PER_BIT cycles; the reply occupies 10·CLKS_PER_BIT cycles.
- `busy` falls on the cycle after the stop bit ends.
- The error outputs are registered pulses, never two cycles wide.
- Simultaneous events: a framing error and a timeout in the same cycle give a single `con_error` pulse.

## Configuration
- `BUS_NODE_TIMEOUT_EN` defined:
  - A counter starts when WAIT_CRC is entered and is cleared by a start-bit detection.
  - Reaching TIMEOUT_CLKS discards the candidate, pulses `con_error` and → WAIT_DATA.
- `BUS_NODE_TIMEOUT_EN` undefined: WAIT_CRC waits indefinitely; no counter is synthesized.

## Test plan
- Valid frame 0xA5, 0x72 → `done` pulses once, `readdata` = 0xA5, `tx` sends 0x06, `busy` high for 10·CLKS_PER_BIT cycles.
- Frame 0x01, 0x08 (correct CRC is 0x07) → `crc_error` pulses, `readdata` keeps its prior value, `tx` sends 0x15.
- Data byte 0x3C sent with stop bit = 0, then 0x01, 0x07 → `con_error` pulses once, then `done` with `readdata` = 0x01.
- With `BUS_NODE_TIMEOUT_EN`: send 0x55, then idle TIMEOUT_CLKS + 10 cycles → `con_error` pulses. A following 0x01, 0x07 is accepted.
- Back-to-back frames 0xA5, 0x72 then 0x01, 0x07, the second arriving during the ACK → both accepted, two ACKs sent.
- Assert `reset` for 1 cycle mid-reply → `tx` = 1 and `busy` = 0 next cycle; the next valid frame is accepted normally.
